// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle two's-complement adder/subtractor.
// Computes S = X + Y (sub=0) or S = X - Y (sub=1), DIGIT bits per clock,
// with the inter-digit carry held in a flop. One operation takes
// N = WIDTH/DIGIT RUN cycles followed by a one-cycle DONE state.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - operation request, sampled in IDLE or DONE only
//   sub    - 0 = add, 1 = subtract (sampled with start)
//   X, Y   - operands (sampled with start)
//   busy   - high while an operation is in progress
//   done   - one-cycle pulse when S and the flags are updated
//   S      - result, held until the next completion
//   Cout   - carry out of the MSB (for subtract: 1 = no borrow)
//   Ovf    - signed overflow
//   Zero   - S == 0
module serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf,
    output logic             Zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Ripple-carry digit adder over the low DIGIT bits of the operand regs.
    logic [DIGIT-1:0] dsum;
    logic [DIGIT:0]   c;

    always_comb begin
        c    = '0;
        dsum = '0;
        c[0] = carry_q;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            dsum[i]  = a_q[i] ^ b_q[i] ^ c[i];
            c[i+1]   = (a_q[i] & b_q[i]) | (c[i] & (a_q[i] ^ b_q[i]));
        end
    end

    // New digit enters the result register from the MSB end; after N
    // digits the least significant digit has reached bit 0.
    logic [WIDTH-1:0] dsum_ext;
    logic [WIDTH-1:0] res_next;
    logic             last_digit;

    always_comb begin
        dsum_ext            = '0;
        dsum_ext[DIGIT-1:0] = dsum;
        res_next            = (r_q >> DIGIT) | (dsum_ext << (WIDTH - DIGIT));
        last_digit          = (cnt_q == CW'(N - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        busy_d  = busy_q;
        done_d  = done_q;

        case (state_q)
            IDLE, DONE: begin
                done_d = 1'b0;
                busy_d = 1'b0;
                if (start) begin
                    // Subtract as X + ~Y + 1: invert Y here, inject the +1 as carry-in.
                    a_d     = X;
                    b_d     = Y ^ {WIDTH{sub}};
                    carry_d = sub;
                    cnt_d   = '0;
                    r_d     = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                r_d     = res_next;
                carry_d = c[DIGIT];
                cnt_d   = cnt_q + 1'b1;
                if (last_digit) begin
                    s_d     = res_next;
                    cout_d  = c[DIGIT];
                    // c[DIGIT-1] is the carry into the MSB on the final digit.
                    ovf_d   = c[DIGIT-1] ^ c[DIGIT];
                    zero_d  = (res_next == '0);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign S    = s_q;
    assign Cout = cout_q;
    assign Ovf  = ovf_q;
    assign Zero = zero_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Testbench for serial_addsub: three instances (DIGIT = 4, 16, 1) share
// clock, reset and request inputs; each has its own outputs.
module tb_serial_addsub;

    localparam int W    = 16;
    localparam int NDUT = 3;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           sub   = 1'b0;
    logic [W-1:0]   x     = '0;
    logic [W-1:0]   y     = '0;

    logic           busy_w [NDUT];
    logic           done_w [NDUT];
    logic           cout_w [NDUT];
    logic           ovf_w  [NDUT];
    logic           zero_w [NDUT];
    logic [W-1:0]   s_w    [NDUT];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(W), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .X(x), .Y(y),
        .busy(busy_w[0]), .done(done_w[0]), .S(s_w[0]),
        .Cout(cout_w[0]), .Ovf(ovf_w[0]), .Zero(zero_w[0])
    );

    serial_addsub #(.WIDTH(W), .DIGIT(16)) u_d16 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .X(x), .Y(y),
        .busy(busy_w[1]), .done(done_w[1]), .S(s_w[1]),
        .Cout(cout_w[1]), .Ovf(ovf_w[1]), .Zero(zero_w[1])
    );

    serial_addsub #(.WIDTH(W), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .X(x), .Y(y),
        .busy(busy_w[2]), .done(done_w[2]), .S(s_w[2]),
        .Cout(cout_w[2]), .Ovf(ovf_w[2]), .Zero(zero_w[2])
    );

    function automatic int lat_exp(input int d);
        case (d)
            0:       return 4;
            1:       return 1;
            default: return 16;
        endcase
    endfunction

    // Reference model: plain modular arithmetic and sign rules.
    function automatic void model(input logic sb, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] s, output logic co,
                                  output logic ov, output logic z);
        logic [W:0] full;
        if (sb) full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else    full = {1'b0, a} + {1'b0, b};
        s  = full[W-1:0];
        co = full[W];
        if (sb) ov = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        else    ov = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        z  = (s == '0);
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Returns at the falling edge after the edge that samples start.
    task automatic start_pulse(input logic sb, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        sub   = sb;
        x     = a;
        y     = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done0(output int lat);
        lat = 0;
        while (lat < 30) begin
            @(negedge clk);
            lat++;
            if (done_w[0]) break;
        end
        if (!done_w[0]) lat = -1;
    endtask

    typedef struct {
        logic         sb;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        logic         z;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat;
        int           cnt;
        int           last_done;
        logic [W-1:0] es;
        logic         eco, eov, ez;
        logic         sbs [4];
        logic [W-1:0] as  [4];
        logic [W-1:0] bs  [4];

        tbl[0] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1};
        tbl[7] = '{1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 16'h7FFF, 16'hFFFF, 16'h8000, 1'b0, 1'b1, 1'b0};
        tbl[9] = '{1'b0, 16'h00F0, 16'h0F10, 16'h1000, 1'b0, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("rst_busy[%0d]", d), 64'(busy_w[d]), 64'd0);
            check($sformatf("rst_done[%0d]", d), 64'(done_w[d]), 64'd0);
            check($sformatf("rst_S[%0d]", d),    64'(s_w[d]),    64'd0);
            check($sformatf("rst_cout[%0d]", d), 64'(cout_w[d]), 64'd0);
            check($sformatf("rst_ovf[%0d]", d),  64'(ovf_w[d]),  64'd0);
            check($sformatf("rst_zero[%0d]", d), 64'(zero_w[d]), 64'd1);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed table on the DIGIT=4 instance
        for (int i = 0; i < 10; i++) begin
            start_pulse(tbl[i].sb, tbl[i].a, tbl[i].b);
            wait_done0(lat);
            check($sformatf("tbl%0d_lat", i),  64'(lat),       64'd4);
            check($sformatf("tbl%0d_S", i),    64'(s_w[0]),    64'(tbl[i].s));
            check($sformatf("tbl%0d_cout", i), 64'(cout_w[0]), 64'(tbl[i].co));
            check($sformatf("tbl%0d_ovf", i),  64'(ovf_w[0]),  64'(tbl[i].ov));
            check($sformatf("tbl%0d_zero", i), 64'(zero_w[0]), 64'(tbl[i].z));
            repeat (20) @(negedge clk);
        end

        // start pulsed with new operands during RUN is ignored
        start_pulse(1'b0, 16'h1111, 16'h2222);
        x   = 16'hAAAA;
        y   = 16'h5555;
        sub = 1'b1;
        cnt = 0;
        lat = -1;
        for (int c = 1; c <= 12; c++) begin
            if (c == 2) begin
                check("run_busy", 64'(busy_w[0]), 64'd1);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done_w[0]) begin
                cnt++;
                if (lat < 0) lat = c;
                check("ign_S", 64'(s_w[0]), 64'h3333);
            end
        end
        start = 1'b0;
        check("ign_done_count", 64'(cnt), 64'd1);
        check("ign_lat", 64'(lat), 64'd4);
        repeat (20) @(negedge clk);

        // start held high through DONE: back-to-back ops every 5 cycles
        sbs[0] = 1'b0; as[0] = 16'h0001; bs[0] = 16'h0002;
        sbs[1] = 1'b1; as[1] = 16'h000A; bs[1] = 16'h0003;
        sbs[2] = 1'b0; as[2] = 16'hFFFF; bs[2] = 16'hFFFF;
        sbs[3] = 1'b1; as[3] = 16'h0000; bs[3] = 16'h0000;
        @(negedge clk);
        sub = sbs[0]; x = as[0]; y = bs[0]; start = 1'b1;
        cnt       = 0;
        last_done = 0;
        for (int k = 0; k < 4; k++) begin
            lat = 0;
            while (lat < 30) begin
                @(negedge clk);
                cnt++;
                lat++;
                if (done_w[0]) break;
            end
            model(sbs[k], as[k], bs[k], es, eco, eov, ez);
            check($sformatf("b2b%0d_seen", k), 64'(done_w[0]), 64'd1);
            check($sformatf("b2b%0d_gap", k),  64'(cnt - last_done), (k == 0) ? 64'd5 : 64'd5);
            check($sformatf("b2b%0d_S", k),    64'(s_w[0]),    64'(es));
            check($sformatf("b2b%0d_cout", k), 64'(cout_w[0]), 64'(eco));
            check($sformatf("b2b%0d_zero", k), 64'(zero_w[0]), 64'(ez));
            last_done = cnt;
            if (k < 3) begin
                sub = sbs[k+1]; x = as[k+1]; y = bs[k+1];
            end
        end
        start = 1'b0;
        repeat (20) @(negedge clk);

        // Reset asserted during the second RUN cycle
        start_pulse(1'b0, 16'h1111, 16'h1111);
        wait_done0(lat);
        check("pre_rst_S", 64'(s_w[0]), 64'h2222);
        repeat (20) @(negedge clk);
        start_pulse(1'b0, 16'h0F0F, 16'h0101);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy_w[0]), 64'd0);
        check("abort_done", 64'(done_w[0]), 64'd0);
        check("abort_S",    64'(s_w[0]),    64'd0);
        check("abort_cout", 64'(cout_w[0]), 64'd0);
        check("abort_zero", 64'(zero_w[0]), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_w[0]) cnt++;
        end
        check("abort_no_done", 64'(cnt), 64'd0);
        check("abort_S_hold",  64'(s_w[0]), 64'd0);

        // Random operations on all three instances
        for (int op = 0; op < 1000; op++) begin
            logic         sb;
            logic [W-1:0] a, b;
            logic         seen [NDUT];
            sb = 1'($urandom_range(0, 1));
            a  = pick();
            b  = pick();
            model(sb, a, b, es, eco, eov, ez);
            for (int d = 0; d < NDUT; d++) seen[d] = 1'b0;
            start_pulse(sb, a, b);
            for (int c = 1; c <= 40; c++) begin
                @(negedge clk);
                for (int d = 0; d < NDUT; d++) begin
                    if (!seen[d] && done_w[d]) begin
                        seen[d] = 1'b1;
                        check($sformatf("rnd%0d_lat[%0d]", op, d),  64'(c),         64'(lat_exp(d)));
                        check($sformatf("rnd%0d_S[%0d]", op, d),    64'(s_w[d]),    64'(es));
                        check($sformatf("rnd%0d_cout[%0d]", op, d), 64'(cout_w[d]), 64'(eco));
                        check($sformatf("rnd%0d_ovf[%0d]", op, d),  64'(ovf_w[d]),  64'(eov));
                        check($sformatf("rnd%0d_zero[%0d]", op, d), 64'(zero_w[d]), 64'(ez));
                    end
                end
                if (seen[0] && seen[1] && seen[2]) break;
            end
            for (int d = 0; d < NDUT; d++)
                check($sformatf("rnd%0d_done_seen[%0d]", op, d), 64'(seen[d]), 64'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
